// File: rtl/ula_seq_pkg.sv
// rtl/ula_seq_pkg.sv - opcodes, status codes, FSM states and opcode check for the ULA op sequencer
package ula_seq_pkg;

   localparam logic [3:0] OP_REP2   = 4'h0;
   localparam logic [3:0] OP_DEC2   = 4'h1;
   localparam logic [3:0] OP_ZNN2   = 4'h2;
   localparam logic [3:0] OP_MED2   = 4'h3;
   localparam logic [3:0] OP_COPY   = 4'h4;
   localparam logic [3:0] OP_REP4   = 4'h8;
   localparam logic [3:0] OP_DEC4   = 4'h9;
   localparam logic [3:0] OP_ZNN4   = 4'hA;
   localparam logic [3:0] OP_MED4   = 4'hB;

   localparam logic [3:0] PARK_CODE = 4'hF;

   localparam logic [1:0] STAT_OK      = 2'd0;
   localparam logic [1:0] STAT_BAD_OP  = 2'd1;
   localparam logic [1:0] STAT_ABORTED = 2'd2;
   localparam logic [1:0] STAT_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      PARK,
      RUN,
      PARK_ABORT,
      RESP
   } seq_state_t;

   function automatic logic is_valid_op(input logic [3:0] op);
      case (op)
         OP_REP2, OP_DEC2, OP_ZNN2, OP_MED2, OP_COPY,
         OP_REP4, OP_DEC4, OP_ZNN4, OP_MED4: is_valid_op = 1'b1;
         default:                            is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ula_seq_watchdog.sv
// rtl/ula_seq_watchdog.sv - run-cycle counter, stale-done mask and timeout compare
// Timeout compare is live only when ULA_SEQ_TIMEOUT_EN is defined.
module ula_seq_watchdog #(
   parameter int DONE_MASK      = 4,
   parameter int CNT_W          = 24,
   parameter int TIMEOUT_CYCLES = 16777215
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             run,
   output logic [CNT_W-1:0] cycles,
   output logic             unmasked,
   output logic             expired
);

   localparam int MW = $clog2(DONE_MASK + 2);

`ifdef ULA_SEQ_TIMEOUT_EN
   localparam logic WD_EN = 1'b1;
`else
   localparam logic WD_EN = 1'b0;
`endif

   logic [CNT_W-1:0] cnt_q;
   logic [MW-1:0]    mask_q;

   // cycles includes the current RUN cycle, so a response latched now reports it
   assign cycles   = (run && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   assign unmasked = (mask_q >= MW'(DONE_MASK));
   assign expired  = WD_EN && (cycles >= CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         mask_q <= '0;
      end else if (clear) begin
         cnt_q  <= '0;
         mask_q <= '0;
      end else if (run) begin
         cnt_q <= cycles;
         if (!unmasked)
            mask_q <= mask_q + MW'(1);
      end
   end

endmodule

// File: rtl/ula_op_sequencer.sv
// rtl/ula_op_sequencer.sv - command-level controller parking and launching the image ULA
// Optional watchdog: define ULA_SEQ_TIMEOUT_EN.
module ula_op_sequencer
   import ula_seq_pkg::*;
#(
   parameter int PARK_CYCLES    = 2,
   parameter int DONE_MASK      = 4,
   parameter int CNT_W          = 24,
   parameter int TIMEOUT_CYCLES = 16777215
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [3:0]       cmd_op,
   output logic             cmd_ready,
   input  logic             abort,
   output logic [3:0]       ula_seletor,
   input  logic             ula_done,
   output logic             busy,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_status,
   output logic [CNT_W-1:0] rsp_cycles
);

   localparam int PW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;

   seq_state_t       state, state_n;
   logic [PW-1:0]    park_cnt, park_cnt_n;
   logic [3:0]       op_q, op_n, sel_q, sel_n;
   logic [1:0]       status_q, status_n;
   logic [CNT_W-1:0] cycles_q, cycles_n, wd_cycles;
   logic             armed, wd_clear, wd_unmasked, wd_expired, park_last;

   assign park_last   = (park_cnt == PW'(PARK_CYCLES - 1));
   // armed keeps cmd_ready low until the first edge after reset release
   assign cmd_ready   = armed && (state == IDLE);
   assign busy        = (state != IDLE);
   assign rsp_valid   = (state == RESP);
   assign ula_seletor = sel_q;
   assign rsp_status  = status_q;
   assign rsp_cycles  = cycles_q;

   ula_seq_watchdog #(
      .DONE_MASK      (DONE_MASK),
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (wd_clear),
      .run      (state == RUN),
      .cycles   (wd_cycles),
      .unmasked (wd_unmasked),
      .expired  (wd_expired)
   );

   always_comb begin
      state_n    = state;
      park_cnt_n = park_cnt;
      op_n       = op_q;
      sel_n      = sel_q;
      status_n   = status_q;
      cycles_n   = cycles_q;
      wd_clear   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (is_valid_op(cmd_op)) begin
                  op_n       = cmd_op;
                  sel_n      = PARK_CODE;
                  park_cnt_n = '0;
                  state_n    = PARK;
               end else begin
                  status_n = STAT_BAD_OP;
                  cycles_n = '0;
                  state_n  = RESP;
               end
            end
         end
         PARK: begin
            if (park_last) begin
               sel_n    = op_q;
               wd_clear = 1'b1;
               state_n  = RUN;
            end else begin
               park_cnt_n = park_cnt + PW'(1);
            end
         end
         RUN: begin
            // done beats abort beats timeout
            if (ula_done && wd_unmasked) begin
               status_n = STAT_OK;
               cycles_n = wd_cycles;
               state_n  = RESP;
            end else if (abort || wd_expired) begin
               status_n   = abort ? STAT_ABORTED : STAT_TIMEOUT;
               cycles_n   = wd_cycles;
               sel_n      = PARK_CODE;
               park_cnt_n = '0;
               state_n    = PARK_ABORT;
            end
         end
         PARK_ABORT: begin
            if (park_last)
               state_n = RESP;
            else
               park_cnt_n = park_cnt + PW'(1);
         end
         RESP: begin
            if (rsp_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         park_cnt <= '0;
         op_q     <= '0;
         sel_q    <= PARK_CODE;
         status_q <= STAT_OK;
         cycles_q <= '0;
         armed    <= 1'b0;
      end else begin
         state    <= state_n;
         park_cnt <= park_cnt_n;
         op_q     <= op_n;
         sel_q    <= sel_n;
         status_q <= status_n;
         cycles_q <= cycles_n;
         armed    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// tb/tb_ula_op_sequencer.sv - self-checking bench for ula_op_sequencer with a ULA done model
module tb_ula_op_sequencer;
   import ula_seq_pkg::*;

   localparam int PC = 2;
   localparam int DM = 4;
   localparam int TO = 50;
   localparam int NEVER = 1 << 30;

   logic        clk, reset, cmd_valid, cmd_ready, abort, ula_done, busy, rsp_valid, rsp_ready;
   logic [3:0]  cmd_op, ula_seletor;
   logic [1:0]  rsp_status;
   logic [23:0] rsp_cycles;

   int errors = 0;
   int checks = 0;

   // ULA environment: env_t counts cycles since the selector settled on env_op
   logic [3:0] env_op;
   int         env_t, env_delay, env_stale, env_abort;
   bit         env_hold, env_stale_idle;

   ula_op_sequencer #(
      .PARK_CYCLES(PC), .DONE_MASK(DM), .CNT_W(24), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .abort(abort), .ula_seletor(ula_seletor),
      .ula_done(ula_done), .busy(busy), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ula_seletor != PARK_CODE && ula_seletor == env_op)
         env_t = (env_t < 0) ? 0 : env_t + 1;
      else
         env_t = -1;
      if (env_t >= 0)
         ula_done = (env_t < env_stale) ||
                    (env_hold ? (env_t >= env_delay) : (env_t == env_delay));
      else
         ula_done = env_stale_idle;
      abort = (env_t >= 0) && (env_t == env_abort);
   endtask

   // Outcome of a job from the timeline of done/abort/timeout relative to the first RUN cycle
   function automatic void ref_model(input int delay, input bit hold, input int stale,
                                     input int abort_at, output logic [1:0] st, output int cyc);
      bit d;
      st  = STAT_OK;
      cyc = 0;
      for (int t = 0; t < 100000; t++) begin
         d = (t < stale) || (hold ? (t >= delay) : (t == delay));
         if (t >= DM && d) begin st = STAT_OK; cyc = t + 1; return; end
         if (t == abort_at) begin st = STAT_ABORTED; cyc = t + 1; return; end
`ifdef ULA_SEQ_TIMEOUT_EN
         if (t + 1 >= TO) begin st = STAT_TIMEOUT; cyc = t + 1; return; end
`endif
      end
   endfunction

   task automatic issue(input logic [3:0] op, input string tag);
      int n;
      cmd_op    = op;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      check({tag, ":cmd_ready"}, cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(input int hold_cycles, input string tag);
      logic [1:0]  st0;
      logic [23:0] cy0;
      st0 = rsp_status;
      cy0 = rsp_cycles;
      for (int i = 0; i < hold_cycles; i++) begin
         tick();
         check({tag, ":hold_valid"}, rsp_valid, 1);
         check({tag, ":hold_status"}, rsp_status, st0);
         check({tag, ":hold_cycles"}, rsp_cycles, cy0);
         check({tag, ":hold_ready"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, ":rsp_done"}, rsp_valid, 0);
      check({tag, ":busy_drop"}, busy, 0);
      check({tag, ":ready_back"}, cmd_ready, 1);
   endtask

   task automatic run_job(input logic [3:0] op, input int delay, input bit hold, input int stale,
                          input bit stale_idle, input int abort_at, input int hold_cycles,
                          input string tag);
      logic [1:0] exp_st;
      int         exp_cyc, n;
      env_op = op; env_delay = delay; env_hold = hold; env_stale = stale;
      env_stale_idle = stale_idle; env_abort = abort_at;
      ref_model(delay, hold, stale, abort_at, exp_st, exp_cyc);
      issue(op, tag);
      check({tag, ":busy"}, busy, 1);
      check({tag, ":sel_park0"}, ula_seletor, PARK_CODE);
      tick();
      check({tag, ":sel_park1"}, ula_seletor, PARK_CODE);
      tick();
      check({tag, ":sel_run"}, ula_seletor, op);
      n = 0;
      while (!rsp_valid && n < 1000) begin tick(); n++; end
      check({tag, ":rsp_valid"}, rsp_valid, 1);
      check({tag, ":latency"}, n, exp_cyc + ((exp_st == STAT_OK) ? 0 : PC));
      check({tag, ":status"}, rsp_status, exp_st);
      check({tag, ":cycles"}, rsp_cycles, exp_cyc);
      check({tag, ":sel_after"}, ula_seletor, (exp_st == STAT_OK) ? op : PARK_CODE);
      finish_rsp(hold_cycles, tag);
   endtask

   task automatic bad_job(input logic [3:0] op, input string tag);
      logic [3:0] sel0;
      sel0 = ula_seletor;
      issue(op, tag);
      check({tag, ":rsp_valid"}, rsp_valid, 1);
      check({tag, ":status"}, rsp_status, STAT_BAD_OP);
      check({tag, ":cycles"}, rsp_cycles, 0);
      check({tag, ":sel_kept"}, ula_seletor, sel0);
      check({tag, ":busy"}, busy, 1);
      finish_rsp(1, tag);
   endtask

   logic [3:0] valid_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
   logic [3:0] bad_ops   [7] = '{4'h5, 4'h6, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; abort = 1'b0;
      ula_done = 1'b0; rsp_ready = 1'b0;
      env_op = PARK_CODE; env_t = -1; env_delay = NEVER; env_hold = 1'b0;
      env_stale = 0; env_stale_idle = 1'b0; env_abort = -1;

      repeat (3) @(posedge clk);
      #1;
      check("rst:cmd_ready", cmd_ready, 0);
      check("rst:sel", ula_seletor, PARK_CODE);
      check("rst:busy", busy, 0);
      check("rst:rsp_valid", rsp_valid, 0);
      check("rst:status", rsp_status, 0);
      check("rst:cycles", rsp_cycles, 0);
      reset = 1'b1;
      check("rel:ready_low", cmd_ready, 0);
      tick();
      check("rel:ready_high", cmd_ready, 1);

      // DEC2, done held high from 100 cycles after settle; response held off 10 cycles
      run_job(4'h1, 100, 1'b1, 0, 1'b0, -1, 10, "dec2");
      bad_job(4'h5, "badop5");
      // stale done from the previous job covers park and the whole mask window
      run_job(4'h8, 30, 1'b0, DM, 1'b1, -1, 1, "stale");
      run_job(4'h2, NEVER, 1'b0, 0, 1'b0, 20, 1, "abort20");
      run_job(4'h3, 4, 1'b0, 0, 1'b0, -1, 1, "done_at_mask");
      run_job(4'h4, 3, 1'b0, 0, 1'b0, 20, 1, "done_in_mask");
      run_job(4'h9, 12, 1'b0, 0, 1'b0, 12, 1, "done_vs_abort");
      run_job(4'hB, NEVER, 1'b0, 0, 1'b0, 2, 1, "abort_in_mask");
      run_job(4'hA, NEVER, 1'b0, 0, 1'b0, 60, 1, "no_done");

      for (int i = 0; i < 6; i++) begin
         run_job(valid_ops[$urandom_range(0, 8)], $urandom_range(4, 60), 1'($urandom_range(0, 1)),
                 0, 1'b0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : -1,
                 $urandom_range(0, 3), "rand");
         bad_job(bad_ops[$urandom_range(0, 6)], "rand_bad");
      end

      // asynchronous reset in the middle of RUN
      env_op = 4'h2; env_delay = NEVER; env_hold = 1'b0; env_stale = 0;
      env_stale_idle = 1'b0; env_abort = -1;
      issue(4'h2, "mid_rst");
      tick();
      tick();
      repeat (5) tick();
      check("mid_rst:in_run", ula_seletor, 4'h2);
      reset = 1'b0;
      #1;
      check("mid_rst:sel", ula_seletor, PARK_CODE);
      check("mid_rst:busy", busy, 0);
      check("mid_rst:rsp_valid", rsp_valid, 0);
      check("mid_rst:cmd_ready", cmd_ready, 0);
      tick();
      reset = 1'b1;
      check("mid_rst:ready_low", cmd_ready, 0);
      tick();
      check("mid_rst:ready_high", cmd_ready, 1);
      check("mid_rst:sel_parked", ula_seletor, PARK_CODE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
